// File: rtl/pipe_mux_reg.sv
// ---------------------------------------------------------------------------
// pipe_mux_reg
//
// Pipeline register with a channel-select multiplexer in front of it. One of
// N_IN flattened input channels is chosen by 'sel' and captured on the next
// rising clock edge. Stall, flush and reset controls are provided. A sticky
// flag records any attempt to load an out-of-range channel.
//
// Optional feature:
//   PIPE_MUX_ERR_CNT_EN - when defined, err_cnt is a saturating counter of
//                         illegal-select events. When undefined, err_cnt is
//                         tied to zero and no counter flops are built.
//
// Parameters:
//   WIDTH        data width of each channel and of out_data
//   N_IN         number of input channels (2..16)
//   ILLEGAL_VAL  value captured when sel selects a non-existent channel
//   ERR_CNT_W    width of err_cnt
//   SEL_W        derived select width, max(1, clog2(N_IN)); not overridable
//
// Ports:
//   clk       in   1            sole clock, rising edge
//   rst       in   1            synchronous active-high reset
//   in_data   in   N_IN*WIDTH   channel k at bits [k*WIDTH +: WIDTH]
//   sel       in   SEL_W        channel select
//   in_valid  in   1            current input is a real operand
//   stall     in   1            hold register contents
//   flush     in   1            replace register contents with a bubble
//   err_clr   in   1            clear error state
//   out_data  out  WIDTH        registered selected data
//   out_valid out  1            registered valid
//   sel_err   out  1            sticky illegal-select flag
//   err_cnt   out  ERR_CNT_W    illegal-select count (zero when disabled)
// ---------------------------------------------------------------------------
module pipe_mux_reg #(
    parameter int                WIDTH       = 32,
    parameter int                N_IN        = 4,
    parameter logic [WIDTH-1:0]  ILLEGAL_VAL = WIDTH'(32'hDEADBEEF),
    parameter int                ERR_CNT_W   = 8,
    localparam int               SEL_W       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic                   sel_err,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    logic             sel_legal;
    logic [WIDTH-1:0] chan_data;
    logic [WIDTH-1:0] sel_data;
    logic             load;
    logic             illegal_evt;

    // Channel lookup. Matching sel against each existing channel index (rather
    // than comparing sel against N_IN) means a power-of-two N_IN naturally has
    // every select code legal, and codes beyond the last channel simply never
    // match, leaving sel_legal low.
    always_comb begin
        sel_legal = 1'b0;
        chan_data = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_legal = 1'b1;
                chan_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // A normal load happens only when neither flush nor stall is active. An
    // illegal event is restricted to real (valid) loads so that bubbles,
    // stalled cycles and flushed cycles can never raise the error flag.
    always_comb begin
        load        = !flush && !stall;
        sel_data    = sel_legal ? chan_data : ILLEGAL_VAL;
        illegal_evt = load && in_valid && !sel_legal;
    end

    // Data/valid register. Priority is reset, then flush, then stall, then a
    // normal load. Invalid loads capture zero so the register never carries
    // stale data alongside out_valid=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_data  <= in_valid ? sel_data : '0;
        end
    end

    // Sticky error flag. A new illegal event wins over a clear in the same
    // cycle so that an error is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (illegal_evt) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

`ifdef PIPE_MUX_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating illegal-event counter. A clear coinciding with an illegal
    // event restarts the count at one, because that event still happened.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (illegal_evt) begin
            if (err_clr) begin
                err_cnt_q <= ERR_CNT_W'(1);
            end else if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    // Counter disabled: the output is a constant and no flops are built.
    assign err_cnt = '0;
`endif

endmodule
